// File: rtl/mem_log_ctrl.sv
// Capture/readout controller for the logger block RAM: fills the RAM with one
// burst of samples from address 0, then streams it back on a valid/ready port.
module mem_log_ctrl #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_NBIT = 15
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_clear,
  input  logic                     i_sample_valid,
  input  logic [RAM_WIDTH-1:0]     i_sample,
  input  logic                     i_read_start,
  output logic                     o_ram_we,
  output logic [RAM_ADDR_NBIT-1:0] o_ram_waddr,
  output logic [RAM_WIDTH-1:0]     o_ram_wdata,
  output logic                     o_ram_re,
  output logic [RAM_ADDR_NBIT-1:0] o_ram_raddr,
  input  logic [RAM_WIDTH-1:0]     i_ram_rdata,
  output logic [RAM_WIDTH-1:0]     o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_busy,
  output logic                     o_full,
  output logic                     o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_FULL,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_OUT
  } state_e;

  localparam logic [RAM_ADDR_NBIT-1:0] LAST_ADDR = '1;

  state_e                   state_q, state_d;
  logic [RAM_ADDR_NBIT-1:0] wptr_q, wptr_d;
  logic [RAM_ADDR_NBIT-1:0] rptr_q, rptr_d;
  logic [RAM_WIDTH-1:0]     out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     done_q, done_d;
  logic                     wr_fire;
  logic                     out_fire;

  // A write issues on any valid sample in CAPTURE, even alongside i_clear.
  assign wr_fire  = (state_q == S_CAPTURE) && i_sample_valid;
  assign out_fire = (state_q == S_RD_OUT) && i_out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (i_start) state_d = S_CAPTURE;
        S_CAPTURE: if (wr_fire && (wptr_q == LAST_ADDR)) state_d = S_FULL;
        S_FULL: begin
          if (i_start)           state_d = S_CAPTURE;
          else if (i_read_start) state_d = S_RD_REQ;
        end
        S_RD_REQ:  state_d = S_RD_WAIT;
        S_RD_WAIT: state_d = S_RD_OUT;
        S_RD_OUT:  if (out_fire) state_d = (rptr_q == LAST_ADDR) ? S_FULL : S_RD_REQ;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    if (wr_fire) wptr_d = wptr_q + 1'b1;
    if (i_clear) begin
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_start) wptr_d = '0;
        S_FULL: begin
          if (i_start)           wptr_d = '0;
          else if (i_read_start) rptr_d = '0;
        end
        S_RD_WAIT: begin
          out_data_d  = i_ram_rdata;
          out_valid_d = 1'b1;
        end
        S_RD_OUT: begin
          if (out_fire) begin
            out_valid_d = 1'b0;
            if (rptr_q == LAST_ADDR) done_d = 1'b1;
            else                     rptr_d = rptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Addresses and write data are forced to zero whenever their port is idle.
  always_comb begin
    o_ram_we    = wr_fire;
    o_ram_waddr = (state_q == S_CAPTURE) ? wptr_q : '0;
    o_ram_wdata = wr_fire ? i_sample : '0;
    o_ram_re    = (state_q == S_RD_REQ);
    o_ram_raddr = (state_q == S_RD_REQ) ? rptr_q : '0;
    o_out_data  = out_data_q;
    o_out_valid = out_valid_q;
    o_busy      = (state_q == S_CAPTURE) || (state_q == S_RD_REQ) ||
                  (state_q == S_RD_WAIT) || (state_q == S_RD_OUT);
    o_full      = (state_q == S_FULL);
    o_done      = done_q;
  end

endmodule

// File: tb/tb_mem_log_ctrl.sv
// Self-checking bench for mem_log_ctrl with a 16-word RAM model attached:
// vector table, hand sequences for burst/readout corners, randomized trials.
module tb_mem_log_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start, clear, sample_valid, read_start, out_ready;
  logic [DW-1:0] sample;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata, out_data;
  logic          out_valid, busy, full, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_log_ctrl #(.RAM_WIDTH(DW), .RAM_ADDR_NBIT(AW)) dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_clear       (clear),
    .i_sample_valid(sample_valid),
    .i_sample      (sample),
    .i_read_start  (read_start),
    .o_ram_we      (ram_we),
    .o_ram_waddr   (ram_waddr),
    .o_ram_wdata   (ram_wdata),
    .o_ram_re      (ram_re),
    .o_ram_raddr   (ram_raddr),
    .i_ram_rdata   (ram_rdata),
    .o_out_data    (out_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_busy        (busy),
    .o_full        (full),
    .o_done        (done)
  );

  // Simple dual-port RAM with one-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  initial ram_rdata = '0;
  always @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_raddr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},     ram_we, 0);
    check({tag, "_waddr"},  ram_waddr, 0);
    check({tag, "_wdata"},  ram_wdata, 0);
    check({tag, "_re"},     ram_re, 0);
    check({tag, "_raddr"},  ram_raddr, 0);
    check({tag, "_odata"},  out_data, 0);
    check({tag, "_ovalid"}, out_valid, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_full"},   full, 0);
    check({tag, "_done"},   done, 0);
  endtask

  // Readout of words 0x100+w from FULL; optionally stall one word.
  task automatic do_readout(input int stall_word, input int stall_len);
    int last_cyc;
    int n;
    out_ready  = 1'b1;
    read_start = 1'b1;
    #1;
    check("rd_from_full", full, 1);
    tick();
    read_start = 1'b0;
    last_cyc   = 0;
    for (int w = 0; w < DEPTH; w++) begin
      n = 0;
      #1;
      while (!out_valid && n < 10) begin
        if (ram_re) check("rd_raddr", ram_raddr, w);
        tick();
        n++;
      end
      check("rd_valid", out_valid, 1);
      check("rd_data", out_data, 32'h100 + w);
      if (w > 0) check("rd_spacing", cyc - last_cyc, (w - 1 == stall_word) ? 3 + stall_len : 3);
      last_cyc = cyc;
      if (w == stall_word) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          check("bp_valid", out_valid, 1);
          check("bp_data", out_data, 32'h100 + w);
          check("bp_no_re", ram_re, 0);
        end
        out_ready = 1'b1;
      end
      tick();
      check("rd_valid_drop", out_valid, 0);
      check("rd_done", done, (w == DEPTH - 1) ? 1 : 0);
    end
    check("rd_back_full", full, 1);
    tick();
    check("rd_done_one_cycle", done, 0);
    check("rd_still_full", full, 1);
  endtask

  typedef struct {
    logic          start;
    logic          clear;
    logic          valid;
    logic          rd;
    logic [DW-1:0] sample;
    logic          exp_we;
    logic [AW-1:0] exp_waddr;
    logic          exp_busy;
    logic          exp_full;
  } vec_t;

  vec_t vt [17];

  initial begin
    int            cnt, g, idx, dseen, n;
    logic [DW-1:0] q[$];

    // Gapped capture with ignored pulses, clear at address 7, restart from 0.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA0, 1'b1, 4'd0, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA1, 1'b1, 4'd1, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd2, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hA2, 1'b1, 4'd2, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA3, 1'b1, 4'd3, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA4, 1'b1, 4'd4, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA5, 1'b1, 4'd5, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA6, 1'b1, 4'd6, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd7, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hA7, 1'b1, 4'd7, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hB0, 1'b1, 4'd0, 1'b1, 1'b0};
    vt[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'd1, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0; clear = 1'b0; sample_valid = 1'b0; read_start = 1'b0;
    out_ready = 1'b0; sample = '0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      start        = vt[i].start;
      clear        = vt[i].clear;
      sample_valid = vt[i].valid;
      read_start   = vt[i].rd;
      sample       = vt[i].sample;
      #1;
      check($sformatf("tbl%0d_we", i), ram_we, vt[i].exp_we);
      if (vt[i].exp_we) begin
        check($sformatf("tbl%0d_waddr", i), ram_waddr, vt[i].exp_waddr);
        check($sformatf("tbl%0d_wdata", i), ram_wdata, vt[i].sample);
      end
      check($sformatf("tbl%0d_busy", i), busy, vt[i].exp_busy);
      check($sformatf("tbl%0d_full", i), full, vt[i].exp_full);
      check($sformatf("tbl%0d_re", i), ram_re, 0);
      tick();
    end
    start = 1'b0; clear = 1'b0; sample_valid = 1'b0; read_start = 1'b0; sample = '0;

    // Full burst of 16 back-to-back samples.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sample_valid = 1'b1;
      sample       = 32'h100 + i;
      #1;
      check("cap_we", ram_we, 1);
      check("cap_waddr", ram_waddr, i);
      check("cap_wdata", ram_wdata, 32'h100 + i);
      check("cap_not_full", full, 0);
      tick();
    end
    sample_valid = 1'b0;
    #1;
    check("cap_full", full, 1);
    check("cap_idle_busy", busy, 0);
    check("cap_no_we", ram_we, 0);

    do_readout(-1, 0);
    do_readout(3, 5);

    // Randomized capture/readout trials against a queue model.
    for (int trial = 0; trial < 4; trial++) begin
      start      = 1'b1;
      read_start = trial[0];
      #1;
      tick();
      start = 1'b0; read_start = 1'b0;
      cnt = 0; g = 0;
      q.delete();
      while (cnt < DEPTH && g < 200) begin
        sample_valid = ($urandom_range(0, 3) != 0);
        sample       = $urandom;
        #1;
        check("rnd_we", ram_we, sample_valid);
        check("rnd_busy", busy, 1);
        if (sample_valid) begin
          check("rnd_waddr", ram_waddr, cnt);
          check("rnd_wdata", ram_wdata, sample);
          q.push_back(sample);
          cnt++;
        end
        tick();
        g++;
      end
      sample_valid = 1'b0;
      #1;
      check("rnd_cap_count", cnt, DEPTH);
      check("rnd_cap_full", full, 1);

      read_start = 1'b1;
      #1;
      tick();
      read_start = 1'b0;
      idx = 0; g = 0; dseen = 0;
      while (idx < DEPTH && g < 500) begin
        out_ready = 1'($urandom_range(0, 1));
        #1;
        if (done) dseen++;
        if (out_valid && out_ready) begin
          check("rnd_data", out_data, q[idx]);
          idx++;
        end
        tick();
        g++;
      end
      out_ready = 1'b0;
      #1;
      check("rnd_rd_count", idx, DEPTH);
      check("rnd_early_done", dseen, 0);
      check("rnd_done", done, 1);
      check("rnd_rd_full", full, 1);
      tick();
    end

    // Asynchronous reset while a word is held in RD_OUT.
    read_start = 1'b1;
    out_ready  = 1'b0;
    #1;
    tick();
    read_start = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("rst_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_full", full, 0);
    read_start = 1'b1;
    #1;
    tick();
    read_start = 1'b0;
    #1;
    check("post_rst_rd_ignored", busy, 0);
    check("post_rst_no_re", ram_re, 0);
    start = 1'b1;
    tick();
    start        = 1'b0;
    sample_valid = 1'b1;
    sample       = 32'h55;
    #1;
    check("restart_we", ram_we, 1);
    check("restart_waddr", ram_waddr, 0);
    tick();
    sample_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_log_ctrl.md
Name: mem_log_ctrl

Overview:
Capture/readout controller that sits directly upstream of the logger block RAM and drives both of its ports. On a start command it writes a contiguous burst of DSP samples into the RAM from address 0 until the RAM is full. On a readout command it reads the RAM back sequentially and presents each word on a valid/ready output stream.

Parameters:
RAM_WIDTH, 32, sample/word width in bits (must match the RAM).
RAM_ADDR_NBIT, 15, RAM address width; depth = 2**RAM_ADDR_NBIT.

Ports:
clk  in  1  system clock; all logic on rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_start  in  1  single-cycle pulse: begin capture (accepted only in IDLE or FULL).
i_clear  in  1  single-cycle pulse: abort any activity, return to IDLE.
i_sample_valid  in  1  qualifies i_sample.
i_sample  in  RAM_WIDTH  DSP sample to log.
i_read_start  in  1  single-cycle pulse: begin readout (accepted only in FULL).
o_ram_we  out  1  RAM write enable.
o_ram_waddr  out  RAM_ADDR_NBIT  RAM write address.
o_ram_wdata  out  RAM_WIDTH  RAM write data.
o_ram_re  out  1  RAM read enable.
o_ram_raddr  out  RAM_ADDR_NBIT  RAM read address.
i_ram_rdata  in  RAM_WIDTH  RAM read data; valid 1 cycle after o_ram_re.
o_out_data  out  RAM_WIDTH  readout word.
o_out_valid  out  1  o_out_data valid.
i_out_ready  in  1  consumer accepts the word when valid and ready are both high.
o_busy  out  1  high in CAPTURE, RD_REQ, RD_WAIT, RD_OUT.
o_full  out  1  high in FULL.
o_done  out  1  1-cycle pulse when the last word is accepted.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE. All outputs 0: addresses, data, enables, o_out_valid, o_busy, o_full, o_done.
- States: IDLE, CAPTURE, FULL, RD_REQ, RD_WAIT, RD_OUT.
- IDLE:
  - i_start -> CAPTURE, write pointer = 0.
  - i_read_start ignored.
- CAPTURE:
  - On each cycle with i_sample_valid=1, drive o_ram_we=1 combinationally, o_ram_waddr=wptr, o_ram_wdata=i_sample. The write lands at that clock edge; wptr increments.
  - i_sample_valid=0: o_ram_we=0, no increment.
  - When the write at wptr=DEPTH-1 occurs -> FULL. wptr wraps to 0; the RAM is never overwritten in the same capture.
  - i_start during CAPTURE is ignored.
- FULL:
  - i_read_start -> RD_REQ, read pointer = 0.
  - i_start -> CAPTURE (new capture from 0).
  - If both pulse in the same cycle, i_start wins.
- RD_REQ: o_ram_re=1, o_ram_raddr=rptr for exactly one cycle -> RD_WAIT.
- RD_WAIT: on the next edge, register i_ram_rdata into o_out_data, set o_out_valid=1 -> RD_OUT.
- RD_OUT:
  - Hold o_out_data and o_out_valid stable until i_out_ready=1. On the handshake, o_out_valid=0 at the next edge.
  - If rptr=DEPTH-1: pulse o_done for 1 cycle -> FULL. Data is retained, so readout can be repeated.
  - Otherwise rptr+1 -> RD_REQ.
  - Throughput: 1 word per 3 cycles with i_out_ready held high.
- o_ram_re is 0 outside RD_REQ. o_ram_we is 0 outside CAPTURE.
- i_clear (synchronous):
  - From any state -> IDLE next edge; o_out_valid, o_full, o_busy drop.
  - Takes priority over all other inputs.
  - A same-cycle write in CAPTURE is still issued.
- Pointers are unsigned RAM_ADDR_NBIT bits with natural wrap.
- Reset mid-capture or mid-readout: immediate return to reset values. RAM contents are undefined to the controller.

Test Plan:
- Reset: assert i_rst_n=0 mid-RD_OUT (no clock edge) -> all outputs 0 immediately, state IDLE after release.
- Full capture (RAM_ADDR_NBIT=4): i_start, then 16 valid samples 0x100..0x10F -> o_ram_we on 16 cycles, addresses 0..15, o_full=1 the cycle after the 16th write.
- Gapped capture: i_sample_valid toggled 1,0,1,0 -> addresses increment only on valid cycles, no writes on gaps.
- Readout with the RAM model attached, i_out_ready=1 -> words 0x100..0x10F in order, each 3 cycles apart. o_done pulses once, returns to FULL.
- Backpressure: i_out_ready=0 for 5 cycles on word 3 -> o_out_data stays 0x103 with o_out_valid=1 throughout, no extra o_ram_re.
- i_clear during CAPTURE at address 7 -> IDLE next cycle; i_read_start ignored; a new i_start restarts writing at address 0.
